// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester mux arbiter.
// Holds the FSM state encoding, the grant-counter width and the reset
// value of the "last served" flag.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    // Width of the optional per-requester grant-entry counters.
    localparam int CNT_W = 16;

    // After reset requester 1 counts as last served, so requester 0 wins the first tie.
    localparam logic LAST_RST = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating increment for the grant-entry counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
    endfunction

endpackage

// File: rtl/mux2_w.sv
// DW-wide 2:1 mux. sel=0 passes a, sel=1 passes b.
module mux2_w #(
    parameter int DW = 8
) (
    input  logic          sel,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter that owns the select line of a shared 2:1 mux.
// One requester holds the grant for bursts of up to MAX_BURST beats while
// the other is waiting; handover between requesters has no idle cycle.
// Optional feature: define MUX2_ARB_CNT_EN to add the gnt_cnt0/gnt_cnt1
// grant-entry counters (16-bit, saturating).
//
// Output handshake: a beat transfers on every rising edge where
// out_valid & out_ready are both 1. out_valid follows the granted req
// combinationally and out_data is 0 whenever out_valid is 0. The granted
// requester must hold its data stable while stalled; dropping req during a
// stall abandons the beat without a transfer.
module mux2_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [DW-1:0] in0,
    input  logic          req1,
    input  logic [DW-1:0] in1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          sel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy
`ifdef MUX2_ARB_CNT_EN
    ,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
`endif
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] CNT_LAST = BW'(MAX_BURST - 1);
    localparam logic [BW-1:0] BEAT_ONE = BW'(1);

    state_t        state_q, nxt_state;
    logic          last_q, nxt_last;
    logic [BW-1:0] beat_cnt_q, nxt_cnt;
    logic          beat;
    logic          cnt_last;
    logic [DW-1:0] mux_y;

    // Shared datapath: the registered sel steers the mux.
    mux2_w #(.DW(DW)) u_mux (
        .sel (sel),
        .a   (in0),
        .b   (in1),
        .y   (mux_y)
    );

    assign out_valid = ((state_q == G0) & req0) | ((state_q == G1) & req1);
    assign out_data  = out_valid ? mux_y : '0;
    assign busy      = (state_q != IDLE);
    assign beat      = out_valid & out_ready;
    assign cnt_last  = (beat_cnt_q == CNT_LAST);

    // Next-state, last-served and burst-count decisions.
    always_comb begin
        nxt_state = state_q;
        nxt_last  = last_q;
        nxt_cnt   = beat_cnt_q;
        case (state_q)
            IDLE: begin
                // On a tie the requester that was not served last wins.
                if (req0 && (!req1 || last_q)) begin
                    nxt_state = G0;
                end else if (req1) begin
                    nxt_state = G1;
                end
            end
            G0: begin
                if (!req0 || (beat && cnt_last && req1)) begin
                    nxt_last  = 1'b0;
                    nxt_cnt   = '0;
                    nxt_state = req1 ? G1 : IDLE;
                end else if (beat) begin
                    nxt_cnt = cnt_last ? '0 : beat_cnt_q + BEAT_ONE;
                end
            end
            G1: begin
                if (!req1 || (beat && cnt_last && req0)) begin
                    nxt_last  = 1'b1;
                    nxt_cnt   = '0;
                    nxt_state = req0 ? G0 : IDLE;
                end else if (beat) begin
                    nxt_cnt = cnt_last ? '0 : beat_cnt_q + BEAT_ONE;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_cnt   = '0;
            end
        endcase
    end

    // FSM registers; grant and select outputs are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= LAST_RST;
            beat_cnt_q <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            sel        <= 1'b0;
        end else begin
            state_q    <= nxt_state;
            last_q     <= nxt_last;
            beat_cnt_q <= nxt_cnt;
            gnt0       <= (nxt_state == G0);
            gnt1       <= (nxt_state == G1);
            sel        <= (nxt_state == G1);
        end
    end

`ifdef MUX2_ARB_CNT_EN
    // Count entries into each grant state, saturating at the counter maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if ((nxt_state == G0) && (state_q != G0)) begin
                gnt_cnt0 <= sat_inc(gnt_cnt0);
            end
            if ((nxt_state == G1) && (state_q != G1)) begin
                gnt_cnt1 <= sat_inc(gnt_cnt1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench for mux2_arbiter: directed scenarios plus a random
// phase, all checked against a behavioural owner/burst model.
module tb_mux2_arbiter;

    localparam int DW = 8;
    localparam int MB = 4;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, out_ready;
    logic [DW-1:0] in0, in1;
    logic          gnt0, gnt1, sel, out_valid, busy;
    logic [DW-1:0] out_data;
`ifdef MUX2_ARB_CNT_EN
    logic [15:0]   gnt_cnt0, gnt_cnt1;
`endif

    always #5 clk = ~clk;

    mux2_arbiter #(.DW(DW), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .in0       (in0),
        .req1      (req1),
        .in1       (in1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef MUX2_ARB_CNT_EN
        ,
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1)
`endif
    );

    // ---------------- scoreboard state ----------------
    int compared   = 0;
    int mismatched = 0;

    // Reference model: which requester owns the mux (-1 = nobody), who was
    // served last, beats taken in the current burst, and grant entries.
    int m_own, m_last, m_beats, m_cnt0, m_cnt1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rq(input int x);
        return (x == 0) ? req0 : req1;
    endfunction

    function automatic logic [DW-1:0] dq(input int x);
        return (x == 0) ? in0 : in1;
    endfunction

    task automatic model_reset();
        m_own   = -1;
        m_last  = 1;
        m_beats = 0;
        m_cnt0  = 0;
        m_cnt1  = 0;
    endtask

    // Compare every output against the model for the current cycle.
    task automatic check_outputs();
        logic v;
        v = (m_own >= 0) && rq(m_own);
        chk("gnt0", {31'd0, gnt0}, {31'd0, m_own == 0});
        chk("gnt1", {31'd0, gnt1}, {31'd0, m_own == 1});
        chk("sel", {31'd0, sel}, {31'd0, m_own == 1});
        chk("busy", {31'd0, busy}, {31'd0, m_own >= 0});
        chk("out_valid", {31'd0, out_valid}, {31'd0, v});
        chk("out_data", {24'd0, out_data}, v ? {24'd0, dq(m_own)} : 32'd0);
`ifdef MUX2_ARB_CNT_EN
        chk("gnt_cnt0", {16'd0, gnt_cnt0}, m_cnt0);
        chk("gnt_cnt1", {16'd0, gnt_cnt1}, m_cnt1);
`endif
    endtask

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_step();
        int prev, x, y;
        logic b;
        prev = m_own;
        if (m_own < 0) begin
            if (req0 && req1) m_own = 1 - m_last;
            else if (req0)    m_own = 0;
            else if (req1)    m_own = 1;
        end else begin
            x = m_own;
            y = 1 - x;
            b = rq(x) && out_ready;
            if (!rq(x) || (b && (m_beats + 1 == MB) && rq(y))) begin
                m_last  = x;
                m_beats = 0;
                m_own   = rq(y) ? y : -1;
            end else if (b) begin
                m_beats = (m_beats + 1) % MB;
            end
        end
        if (m_own != prev && m_own == 0 && m_cnt0 < 65535) m_cnt0++;
        if (m_own != prev && m_own == 1 && m_cnt1 < 65535) m_cnt1++;
    endtask

    // ---------------- driver tasks ----------------
    // Inputs are set by the caller just after a rising edge; outputs are
    // checked on the falling edge, then the model steps with the edge.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit hold0, hold1;
        bit found;

        rst_n     = 1'b0;
        req0      = 1'b0;
        req1      = 1'b0;
        in0       = '0;
        in1       = '0;
        out_ready = 1'b0;
        model_reset();

        // Reset values.
        #12;
        chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
        chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
        chk("rst_sel", {31'd0, sel}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single requester 0 with fixed data.
        req0      = 1'b1;
        in0       = 8'hA5;
        out_ready = 1'b1;
        cycle();
        chk("g0_entry_gnt0", {31'd0, gnt0}, 32'd1);
        chk("g0_entry_sel", {31'd0, sel}, 32'd0);
        for (int i = 0; i < 6; i++) cycle();
        chk("g0_data", {24'd0, out_data}, 32'h0000_00A5);

        // Both requesting from reset: alternating 4-beat bursts, no idle gap.
        req0 = 1'b0;
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in0 = DW'($urandom);
            in1 = DW'($urandom);
            cycle();
        end
        chk("alt_gnt0_after17", {31'd0, gnt0}, 32'd1);
`ifdef MUX2_ARB_CNT_EN
        chk("cnt0_three", {16'd0, gnt_cnt0}, 32'd3);
        chk("cnt1_two", {16'd0, gnt_cnt1}, 32'd2);
`endif

        // Stall in G1 for three cycles while requester 0 waits.
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (m_own == 1) found = 1'b1;
            else cycle();
        end
        chk("reach_g1", {31'd0, gnt1}, 32'd1);
        out_ready = 1'b0;
        in1       = 8'h3C;
        for (int i = 0; i < 3; i++) cycle();
        chk("stall_gnt1", {31'd0, gnt1}, 32'd1);
        chk("stall_data", {24'd0, out_data}, 32'h0000_003C);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Only requester 1 for a long run: stays in G1 across burst wraps.
        req0 = 1'b0;
        req1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in1 = DW'($urandom);
            cycle();
        end
        chk("solo_g1", {31'd0, gnt1}, 32'd1);

        // Random phase honouring the hold-while-stalled contract.
        for (int i = 0; i < 400; i++) begin
            hold0 = (m_own == 0) && req0 && !out_ready;
            hold1 = (m_own == 1) && req1 && !out_ready;
            req0      = ($urandom_range(0, 9) < 7);
            req1      = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 3) != 0);
            if (!hold0) in0 = DW'($urandom);
            if (!hold1) in1 = DW'($urandom);
            cycle();
        end

        // Asynchronous reset in the middle of a G0 burst.
        req0      = 1'b1;
        req1      = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("pre_rst_gnt0", {31'd0, gnt0}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt0", {31'd0, gnt0}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_data", {24'd0, out_data}, 32'd0);
        chk("arst_sel", {31'd0, sel}, 32'd0);
        model_reset();
        req1 = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_hold_gnt0", {31'd0, gnt0}, 32'd0);
        rst_n = 1'b1;
        cycle();
        chk("post_rst_g0_wins", {31'd0, gnt0}, 32'd1);
        for (int i = 0; i < 6; i++) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
